// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave memory bus arbiter with per-master 1-deep request slots,
// round-robin or fixed-priority grant, and a response timeout for dead slaves.
module mem_bus_arbiter #(
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT        = 1023,
    parameter int TW             = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_m0_DV,
    input  logic [31:0] i_m0_address,
    input  logic [31:0] i_m0_data,
    input  logic [2:0]  i_m0_bhw,
    input  logic        i_m0_write_notread,
    output logic [31:0] o_m0_data,
    output logic        o_m0_DV,
    output logic        o_m0_err,
    output logic        o_m0_drop,

    input  logic        i_m1_DV,
    input  logic [31:0] i_m1_address,
    input  logic [31:0] i_m1_data,
    input  logic [2:0]  i_m1_bhw,
    input  logic        i_m1_write_notread,
    output logic [31:0] o_m1_data,
    output logic        o_m1_DV,
    output logic        o_m1_err,
    output logic        o_m1_drop,

    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_data,
    output logic [2:0]  o_bhw,
    output logic        o_write_notread,
    output logic        o_bus_DV,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_DV,

    output logic        o_grant,
    output logic        o_busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);
    localparam bit            TO_EN    = (TIMEOUT != 0);

    logic        w_req      [2];
    logic [31:0] w_req_addr [2];
    logic [31:0] w_req_data [2];
    logic [2:0]  w_req_bhw  [2];
    logic        w_req_wnr  [2];

    assign w_req[0]      = i_m0_DV;
    assign w_req[1]      = i_m1_DV;
    assign w_req_addr[0] = i_m0_address;
    assign w_req_addr[1] = i_m1_address;
    assign w_req_data[0] = i_m0_data;
    assign w_req_data[1] = i_m1_data;
    assign w_req_bhw[0]  = i_m0_bhw;
    assign w_req_bhw[1]  = i_m1_bhw;
    assign w_req_wnr[0]  = i_m0_write_notread;
    assign w_req_wnr[1]  = i_m1_write_notread;

    logic [1:0]    r_state;
    logic [TW-1:0] r_cnt;
    logic          r_last;
    logic          r_grant;

    logic          r_slot_vld  [2];
    logic [31:0]   r_slot_addr [2];
    logic [31:0]   r_slot_data [2];
    logic [2:0]    r_slot_bhw  [2];
    logic          r_slot_wnr  [2];

    logic [31:0]   r_bus_addr;
    logic [31:0]   r_bus_data;
    logic [2:0]    r_bus_bhw;
    logic          r_bus_wnr;
    logic          r_bus_dv;

    logic          r_rsp_dv   [2];
    logic [31:0]   r_rsp_data [2];
    logic          r_rsp_err  [2];
    logic          r_drop     [2];

    logic          w_idle;
    logic          w_active;
    logic          w_owns   [2];
    logic          w_accept [2];
    logic          w_cand   [2];
    logic          w_win_any;
    logic          w_winner;
    logic [31:0]   w_sel_addr;
    logic [31:0]   w_sel_data;
    logic [2:0]    w_sel_bhw;
    logic          w_sel_wnr;
    logic          w_resp_ok;
    logic          w_timeout;

    assign w_idle   = (r_state == S_IDLE);
    assign w_active = (r_state == S_ISSUE) || (r_state == S_WAIT);

    // A master that owns the in-flight transaction cannot queue behind itself.
    always_comb begin
        for (int m = 0; m < 2; m++) begin
            w_owns[m]   = w_active && (r_grant == 1'(m));
            w_accept[m] = w_req[m] && !r_slot_vld[m] && !w_owns[m];
            w_cand[m]   = w_idle && (r_slot_vld[m] || w_accept[m]);
        end
    end

    always_comb begin
        w_win_any = w_cand[0] || w_cand[1];
        w_winner  = 1'b0;
        if (w_cand[0] && w_cand[1]) begin
            w_winner = (FIXED_PRIORITY != 0) ? 1'b0 : ~r_last;
        end else begin
            w_winner = w_cand[1];
        end
        // A filled slot always holds the older request; otherwise bypass the pulse.
        if (r_slot_vld[w_winner]) begin
            w_sel_addr = r_slot_addr[w_winner];
            w_sel_data = r_slot_data[w_winner];
            w_sel_bhw  = r_slot_bhw[w_winner];
            w_sel_wnr  = r_slot_wnr[w_winner];
        end else begin
            w_sel_addr = w_req_addr[w_winner];
            w_sel_data = w_req_data[w_winner];
            w_sel_bhw  = w_req_bhw[w_winner];
            w_sel_wnr  = w_req_wnr[w_winner];
        end
    end

    assign w_resp_ok = w_active && i_bus_DV;
    assign w_timeout = TO_EN && (r_state == S_WAIT) && (r_cnt == TO_LIMIT) && !i_bus_DV;

    // r_cnt counts cycles since the ISSUE cycle, so a timeout answers TIMEOUT+1 cycles after ISSUE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_last     <= 1'b1;
            r_grant    <= 1'b0;
            r_bus_addr <= '0;
            r_bus_data <= '0;
            r_bus_bhw  <= '0;
            r_bus_wnr  <= 1'b0;
            r_bus_dv   <= 1'b0;
        end else begin
            r_bus_dv <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_win_any) begin
                        r_state    <= S_ISSUE;
                        r_bus_dv   <= 1'b1;
                        r_bus_addr <= w_sel_addr;
                        r_bus_data <= w_sel_data;
                        r_bus_bhw  <= w_sel_bhw;
                        r_bus_wnr  <= w_sel_wnr;
                        r_grant    <= w_winner;
                        r_last     <= w_winner;
                        r_cnt      <= '0;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= r_cnt + TW'(1);
                    r_state <= i_bus_DV ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    if (i_bus_DV || w_timeout) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int m = 0; m < 2; m++) begin
                r_slot_vld[m] <= 1'b0;
                r_rsp_dv[m]   <= 1'b0;
                r_rsp_data[m] <= '0;
                r_rsp_err[m]  <= 1'b0;
                r_drop[m]     <= 1'b0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                r_rsp_dv[m]   <= 1'b0;
                r_rsp_data[m] <= '0;
                r_rsp_err[m]  <= 1'b0;
                r_drop[m]     <= w_req[m] && !w_accept[m];
                if (w_win_any && (w_winner == 1'(m))) begin
                    r_slot_vld[m] <= 1'b0;
                end else if (w_accept[m]) begin
                    r_slot_vld[m] <= 1'b1;
                end
                if ((w_resp_ok || w_timeout) && (r_grant == 1'(m))) begin
                    r_rsp_dv[m]   <= 1'b1;
                    r_rsp_err[m]  <= w_timeout;
                    r_rsp_data[m] <= w_timeout ? 32'h0 : i_bus_data;
                end
            end
        end
    end

    // Slot payload is qualified by r_slot_vld and needs no reset.
    always_ff @(posedge i_clk) begin
        for (int m = 0; m < 2; m++) begin
            if (w_accept[m] && !(w_win_any && (w_winner == 1'(m)))) begin
                r_slot_addr[m] <= w_req_addr[m];
                r_slot_data[m] <= w_req_data[m];
                r_slot_bhw[m]  <= w_req_bhw[m];
                r_slot_wnr[m]  <= w_req_wnr[m];
            end
        end
    end

    assign o_m0_data       = r_rsp_data[0];
    assign o_m0_DV         = r_rsp_dv[0];
    assign o_m0_err        = r_rsp_err[0];
    assign o_m0_drop       = r_drop[0];
    assign o_m1_data       = r_rsp_data[1];
    assign o_m1_DV         = r_rsp_dv[1];
    assign o_m1_err        = r_rsp_err[1];
    assign o_m1_drop       = r_drop[1];

    assign o_bus_address   = r_bus_addr;
    assign o_bus_data      = r_bus_data;
    assign o_bhw           = r_bus_bhw;
    assign o_write_notread = r_bus_wnr;
    assign o_bus_DV        = r_bus_dv;

    assign o_grant         = r_grant;
    assign o_busy          = w_active;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, hand sequences for timeout,
// starvation and reset, then random traffic against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int TO_TB = 8;

    typedef struct packed {
        logic [31:0] m0_data; logic m0_dv; logic m0_err; logic m0_drop;
        logic [31:0] m1_data; logic m1_dv; logic m1_err; logic m1_drop;
        logic [31:0] addr; logic [31:0] wdata; logic [2:0] bhw; logic wnr;
        logic bus_dv; logic grant; logic busy;
    } outs_t;

    typedef struct {
        logic m0v; logic [31:0] m0a; logic m1v; logic [31:0] m1a; logic m1w; logic [31:0] m1d;
        logic sv; logic [31:0] sd;
        logic ebv; logic [31:0] eaddr; logic [31:0] ewd; logic ew; logic [2:0] eb;
        logic em0v; logic em1v; logic [31:0] erd; logic ed0; logic eg;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        t_rst;
    logic        t_m0v, t_m0_wnr, t_m1v, t_m1_wnr, t_bus_dv;
    logic [31:0] t_m0_addr, t_m0_wdata, t_m1_addr, t_m1_wdata, t_bus_data;
    logic [2:0]  t_m0_bhw, t_m1_bhw;

    logic [31:0] a_m0d, a_m1d, a_ba, a_bd, b_m0d, b_m1d, b_ba, b_bd;
    logic        a_m0v, a_m0e, a_m0x, a_m1v, a_m1e, a_m1x, a_w, a_bv, a_g, a_y;
    logic        b_m0v, b_m0e, b_m0x, b_m1v, b_m1e, b_m1x, b_w, b_bv, b_g, b_y;
    logic [2:0]  a_bh, b_bh;

    mem_bus_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT(TO_TB), .TW(16)) dut_rr (
        .i_clk(clk), .i_rst(t_rst),
        .i_m0_DV(t_m0v), .i_m0_address(t_m0_addr), .i_m0_data(t_m0_wdata),
        .i_m0_bhw(t_m0_bhw), .i_m0_write_notread(t_m0_wnr),
        .o_m0_data(a_m0d), .o_m0_DV(a_m0v), .o_m0_err(a_m0e), .o_m0_drop(a_m0x),
        .i_m1_DV(t_m1v), .i_m1_address(t_m1_addr), .i_m1_data(t_m1_wdata),
        .i_m1_bhw(t_m1_bhw), .i_m1_write_notread(t_m1_wnr),
        .o_m1_data(a_m1d), .o_m1_DV(a_m1v), .o_m1_err(a_m1e), .o_m1_drop(a_m1x),
        .o_bus_address(a_ba), .o_bus_data(a_bd), .o_bhw(a_bh), .o_write_notread(a_w),
        .o_bus_DV(a_bv), .i_bus_data(t_bus_data), .i_bus_DV(t_bus_dv),
        .o_grant(a_g), .o_busy(a_y)
    );

    mem_bus_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT(TO_TB), .TW(16)) dut_fp (
        .i_clk(clk), .i_rst(t_rst),
        .i_m0_DV(t_m0v), .i_m0_address(t_m0_addr), .i_m0_data(t_m0_wdata),
        .i_m0_bhw(t_m0_bhw), .i_m0_write_notread(t_m0_wnr),
        .o_m0_data(b_m0d), .o_m0_DV(b_m0v), .o_m0_err(b_m0e), .o_m0_drop(b_m0x),
        .i_m1_DV(t_m1v), .i_m1_address(t_m1_addr), .i_m1_data(t_m1_wdata),
        .i_m1_bhw(t_m1_bhw), .i_m1_write_notread(t_m1_wnr),
        .o_m1_data(b_m1d), .o_m1_DV(b_m1v), .o_m1_err(b_m1e), .o_m1_drop(b_m1x),
        .o_bus_address(b_ba), .o_bus_data(b_bd), .o_bhw(b_bh), .o_write_notread(b_w),
        .o_bus_DV(b_bv), .i_bus_data(t_bus_data), .i_bus_DV(t_bus_dv),
        .o_grant(b_g), .o_busy(b_y)
    );

    outs_t d_rr, d_fp;
    assign d_rr = {a_m0d, a_m0v, a_m0e, a_m0x, a_m1d, a_m1v, a_m1e, a_m1x,
                   a_ba, a_bd, a_bh, a_w, a_bv, a_g, a_y};
    assign d_fp = {b_m0d, b_m0v, b_m0e, b_m0x, b_m1d, b_m1v, b_m1e, b_m1x,
                   b_ba, b_bd, b_bh, b_w, b_bv, b_g, b_y};

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [140:0] act, input logic [140:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Reference model: per instance, a queue-free view of "pending request per master",
    // "a transaction is active, owned by X, issued age cycles ago".
    bit          mv_pend [2][2];
    logic [67:0] mv_pfld [2][2];
    bit          mv_act  [2];
    bit          mv_own  [2];
    int          mv_age  [2];
    bit          mv_last [2];
    outs_t       exp_o   [2];

    task automatic model_step(input int k, input bit fp);
        outs_t       e;
        bit          was_act, fin, c0, c1;
        bit          req [2];
        bit          acc [2];
        logic [67:0] inc [2];
        logic [67:0] f;
        int          w;
        req[0] = t_m0v;
        req[1] = t_m1v;
        inc[0] = {t_m0_wnr, t_m0_bhw, t_m0_wdata, t_m0_addr};
        inc[1] = {t_m1_wnr, t_m1_bhw, t_m1_wdata, t_m1_addr};
        if (t_rst) begin
            for (int x = 0; x < 2; x++) mv_pend[k][x] = 0;
            mv_act[k] = 0; mv_age[k] = 0; mv_last[k] = 1; mv_own[k] = 0;
            exp_o[k] = '0;
            return;
        end
        e = exp_o[k];
        e.m0_dv = 0; e.m0_err = 0; e.m0_data = '0; e.m0_drop = 0;
        e.m1_dv = 0; e.m1_err = 0; e.m1_data = '0; e.m1_drop = 0;
        e.bus_dv = 0;
        was_act = mv_act[k];
        fin = 0;
        if (was_act) begin
            if (t_bus_dv || (mv_age[k] == TO_TB)) begin
                fin = 1;
                if (mv_own[k] == 0) begin
                    e.m0_dv = 1; e.m0_err = !t_bus_dv; e.m0_data = t_bus_dv ? t_bus_data : 32'h0;
                end else begin
                    e.m1_dv = 1; e.m1_err = !t_bus_dv; e.m1_data = t_bus_dv ? t_bus_data : 32'h0;
                end
            end else begin
                mv_age[k]++;
            end
        end
        for (int x = 0; x < 2; x++) begin
            acc[x] = 0;
            if (req[x]) begin
                if (mv_pend[k][x] || (was_act && (mv_own[k] == bit'(x)))) begin
                    if (x == 0) e.m0_drop = 1; else e.m1_drop = 1;
                end else begin
                    acc[x] = 1;
                end
            end
        end
        if (!was_act) begin
            c0 = mv_pend[k][0] || acc[0];
            c1 = mv_pend[k][1] || acc[1];
            if (c0 || c1) begin
                if (c0 && c1) w = fp ? 0 : (mv_last[k] ? 0 : 1);
                else          w = c1 ? 1 : 0;
                f = mv_pend[k][w] ? mv_pfld[k][w] : inc[w];
                mv_pend[k][w] = 0;
                acc[w] = 0;
                {e.wnr, e.bhw, e.wdata, e.addr} = f;
                e.bus_dv = 1;
                e.grant = (w == 1);
                mv_last[k] = (w == 1);
                mv_own[k] = (w == 1);
                mv_act[k] = 1;
                mv_age[k] = 0;
            end
        end
        for (int x = 0; x < 2; x++) begin
            if (acc[x]) begin
                mv_pend[k][x] = 1;
                mv_pfld[k][x] = inc[x];
            end
        end
        if (fin) mv_act[k] = 0;
        e.busy = mv_act[k];
        exp_o[k] = e;
    endtask

    task automatic tick();
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        @(posedge clk);
        #1;
        chk("model_rr", 141'(d_rr), 141'(exp_o[0]));
        chk("model_fp", 141'(d_fp), 141'(exp_o[1]));
    endtask

    task automatic clear_in();
        t_rst = 0;
        t_m0v = 0; t_m0_addr = '0; t_m0_wdata = '0; t_m0_bhw = '0; t_m0_wnr = 0;
        t_m1v = 0; t_m1_addr = '0; t_m1_wdata = '0; t_m1_bhw = '0; t_m1_wnr = 0;
        t_bus_dv = 0; t_bus_data = '0;
    endtask

    function automatic vec_t mk(
        input logic m0v, input logic [31:0] m0a, input logic m1v, input logic [31:0] m1a,
        input logic m1w, input logic [31:0] m1d, input logic sv, input logic [31:0] sd,
        input logic ebv, input logic [31:0] eaddr, input logic [31:0] ewd, input logic ew,
        input logic [2:0] eb, input logic em0v, input logic em1v, input logic [31:0] erd,
        input logic ed0, input logic eg);
        vec_t v;
        v.m0v = m0v; v.m0a = m0a; v.m1v = m1v; v.m1a = m1a; v.m1w = m1w; v.m1d = m1d;
        v.sv = sv; v.sd = sd; v.ebv = ebv; v.eaddr = eaddr; v.ewd = ewd; v.ew = ew; v.eb = eb;
        v.em0v = em0v; v.em1v = em1v; v.erd = erd; v.ed0 = ed0; v.eg = eg;
        return v;
    endfunction

    vec_t tbl[$];
    int   cnt_a, cnt_b, cnt_c, lat;
    bit   got;

    initial begin
        // inputs: m0v m0a | m1v m1a m1w m1d | sv sd || expected after the edge:
        // bus_dv addr wdata wnr bhw | m0_dv m1_dv rdata | m0_drop grant
        tbl.push_back(mk(1, 32'h100, 1, 32'h200, 0, 0, 0, 0,        1, 32'h100, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 32'h100, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hA0,                0, 32'h100, 0, 0, 2, 1, 0, 32'hA0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 32'h200, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hA1,                0, 32'h200, 0, 0, 0, 0, 1, 32'hA1, 0, 1));
        tbl.push_back(mk(1, 32'h104, 1, 32'h204, 0, 0, 0, 0,        1, 32'h104, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 32'h104, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hB0,                0, 32'h104, 0, 0, 2, 1, 0, 32'hB0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     1, 32'h204, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 32'h204, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hB1,                0, 32'h204, 0, 0, 0, 0, 1, 32'hB1, 0, 1));
        tbl.push_back(mk(1, 32'h1000, 0, 0, 0, 0, 0, 0,              1, 32'h1000, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 32'h1000, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 32'h1000, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,          0, 32'h1000, 0, 0, 2, 1, 0, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(1, 32'h3000, 0, 0, 0, 0, 0, 0,              1, 32'h3000, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 32'h3000, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h2000, 1, 32'h55, 0, 0,        0, 32'h3000, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 32'h3000, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h77,                0, 32'h3000, 0, 0, 2, 1, 0, 32'h77, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     1, 32'h2000, 32'h55, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 32'h2000, 32'h55, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 32'h2000, 32'h55, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h1234,              0, 32'h2000, 32'h55, 1, 0, 0, 1, 32'h1234, 0, 1));
        tbl.push_back(mk(1, 32'h4000, 0, 0, 0, 0, 0, 0,              1, 32'h4000, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 32'h4000, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h4004, 0, 0, 0, 0, 0, 0,              0, 32'h4000, 0, 0, 2, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 32'h4000, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h99,                0, 32'h4000, 0, 0, 2, 1, 0, 32'h99, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 32'h4000, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                     0, 32'h4000, 0, 0, 2, 0, 0, 0, 0, 0));

        clear_in();
        t_rst = 1;
        tick();
        tick();
        t_rst = 0;
        chk("reset_rr", 141'(d_rr), 141'(0));
        chk("reset_fp", 141'(d_fp), 141'(0));

        for (int i = 0; i < tbl.size(); i++) begin
            clear_in();
            t_m0v = tbl[i].m0v; t_m0_addr = tbl[i].m0a; t_m0_bhw = 3'd2;
            t_m1v = tbl[i].m1v; t_m1_addr = tbl[i].m1a; t_m1_wnr = tbl[i].m1w;
            t_m1_wdata = tbl[i].m1d; t_m1_bhw = 3'd0;
            t_bus_dv = tbl[i].sv; t_bus_data = tbl[i].sd;
            tick();
            chk($sformatf("vec%0d", i),
                141'({a_bv, a_ba, a_bd, a_w, a_bh, a_m0v, a_m1v, a_m0d | a_m1d, a_m0x, a_g}),
                141'({tbl[i].ebv, tbl[i].eaddr, tbl[i].ewd, tbl[i].ew, tbl[i].eb,
                      tbl[i].em0v, tbl[i].em1v, tbl[i].erd, tbl[i].ed0, tbl[i].eg}));
        end

        // Timeout: silent slave, response must land 9 cycles after the ISSUE cycle.
        clear_in();
        t_m0v = 1; t_m0_addr = 32'h5000;
        tick();
        clear_in();
        chk("to_issue", 141'(a_bv), 141'(1));
        got = 0; lat = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            tick();
            if (a_m0v) begin got = 1; lat = i; end
        end
        chk("to_latency", 141'(lat), 141'(9));
        chk("to_err_data", 141'({a_m0e, a_m0d}), 141'({1'b1, 32'h0}));
        t_bus_dv = 1; t_bus_data = 32'hCAFE;
        tick();
        t_bus_dv = 0;
        chk("late_dv_a", 141'({a_m0v, a_m1v, a_bv}), 141'(0));
        tick();
        chk("late_dv_b", 141'({a_m0v, a_m1v, a_bv}), 141'(0));

        // Starvation: m0 requests every cycle, m1 once; slave answers immediately.
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int i = 0; i < 12; i++) begin
            clear_in();
            t_m0v = 1; t_m0_addr = 32'h6000 + 32'(i);
            t_m1v = (i == 0); t_m1_addr = 32'h6100;
            t_bus_dv = 1; t_bus_data = 32'(i);
            tick();
            cnt_a += int'(b_m1v);
            cnt_b += int'(b_m0v);
            cnt_c += int'(a_m1v);
        end
        chk("fp_m1_starved", 141'(cnt_a), 141'(0));
        chk("fp_m0_served", 141'(cnt_b >= 5), 141'(1));
        chk("rr_m1_served", 141'(cnt_c), 141'(1));
        cnt_a = 0;
        for (int i = 0; i < 6; i++) begin
            clear_in();
            t_bus_dv = 1;
            tick();
            cnt_a += int'(b_m1v);
        end
        chk("fp_m1_after", 141'(cnt_a), 141'(1));

        // Reset in the middle of WAIT with m1 queued behind.
        clear_in();
        t_m0v = 1; t_m0_addr = 32'h7000;
        tick();
        clear_in();
        tick();
        tick();
        t_m1v = 1; t_m1_addr = 32'h7100;
        tick();
        clear_in();
        t_rst = 1;
        tick();
        t_rst = 0;
        chk("rst_mid_rr", 141'(d_rr), 141'(0));
        chk("rst_mid_fp", 141'(d_fp), 141'(0));
        t_bus_dv = 1; t_bus_data = 32'hBAD;
        tick();
        t_bus_dv = 0;
        chk("rst_late_dv", 141'(d_rr), 141'(0));
        tick();
        chk("rst_slot_clear", 141'(d_rr), 141'(0));
        t_m1v = 1; t_m1_addr = 32'h8000; t_m1_wnr = 1; t_m1_wdata = 32'h5A; t_m1_bhw = 3'd1;
        tick();
        clear_in();
        chk("post_rst_m1", 141'({a_bv, a_g, a_ba, a_bd, a_w, a_bh}),
            141'({1'b1, 1'b1, 32'h8000, 32'h5A, 1'b1, 3'd1}));
        t_bus_dv = 1; t_bus_data = 32'h11;
        tick();
        clear_in();
        chk("post_rst_resp", 141'({a_m1v, a_m1e, a_m1d, a_m0v}), 141'({1'b1, 1'b0, 32'h11, 1'b0}));

        // Random traffic against the model, including occasional reset and timeouts.
        for (int i = 0; i < 3000; i++) begin
            t_rst      = ($urandom_range(0, 199) == 0);
            t_m0v      = ($urandom_range(0, 2) == 0);
            t_m0_addr  = $urandom;
            t_m0_wdata = $urandom;
            t_m0_bhw   = 3'($urandom_range(0, 7));
            t_m0_wnr   = 1'($urandom_range(0, 1));
            t_m1v      = ($urandom_range(0, 2) == 0);
            t_m1_addr  = $urandom;
            t_m1_wdata = $urandom;
            t_m1_bhw   = 3'($urandom_range(0, 7));
            t_m1_wnr   = 1'($urandom_range(0, 1));
            t_bus_dv   = ($urandom_range(0, 3) == 0);
            t_bus_data = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
